// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin scheduler in front of a shared multi-cycle ALU
// Latches the granted request, pulses alu_execute, waits ALU_WAIT cycles, captures alu_f and acks.
module alu_sched #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] opcode0,
  input  logic [2:0] opcode1,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [5:0] result,
  output logic [2:0] alu_opcode,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic       alu_execute,
  input  logic [5:0] alu_f,
  output logic       busy,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT);

  state_t     state;
  logic       ptr;
  logic       gnt;
  logic [3:0] wait_cnt;
  logic       pick1;
  logic [2:0] sel_opcode;
  logic [2:0] sel_a;
  logic [2:0] sel_b;

  // ptr=1 gives requester 1 priority when both ask; a lone request always wins
  assign pick1      = req1 & (~req0 | ptr);
  assign sel_opcode = pick1 ? opcode1 : opcode0;
  assign sel_a      = pick1 ? a1 : a0;
  assign sel_b      = pick1 ? b1 : b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      gnt         <= 1'b0;
      wait_cnt    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      result      <= '0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_execute <= 1'b0;
      busy        <= 1'b0;
      done_cnt    <= '0;
    end else begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      alu_execute <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt        <= pick1;
            ptr        <= ~pick1;
            alu_opcode <= sel_opcode;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            busy       <= 1'b1;
            // a no-op request skips the ALU entirely and answers with zero
            if (sel_opcode == 3'b000) begin
              result <= '0;
              ack0   <= ~pick1;
              ack1   <= pick1;
              state  <= RESP;
            end else begin
              alu_execute <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= 4'd1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            result <= alu_f;
            ack0   <= ~gnt;
            ack1   <= gnt;
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          done_cnt <= done_cnt + 8'd1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched with ALU_WAIT=1 and ALU_WAIT=4 instances
// A timed ALU model answers only on the capture cycle; expectations come from request-level arithmetic.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_s [2];
  logic       req1_s [2];
  logic [2:0] opc0_s [2];
  logic [2:0] opc1_s [2];
  logic [2:0] a0_s [2];
  logic [2:0] b0_s [2];
  logic [2:0] a1_s [2];
  logic [2:0] b1_s [2];
  logic       ack0_s [2];
  logic       ack1_s [2];
  logic [5:0] result_s [2];
  logic [2:0] alu_opcode_s [2];
  logic [2:0] alu_a_s [2];
  logic [2:0] alu_b_s [2];
  logic       alu_execute_s [2];
  logic [5:0] alu_f_s [2];
  logic       busy_s [2];
  logic [7:0] done_cnt_s [2];

  int total = 0;
  int bad = 0;
  int exp_done [2];
  int ptr_m [2];

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd1:    r = ia + ib;
      3'd2:    r = ia - ib;
      3'd3:    r = ia * ib;
      3'd4:    r = ia >> ib;
      3'd5:    r = ia << ib;
      3'd6:    r = int'(~(a ^ b));
      3'd7:    r = (ia > ib) ? 1 : 0;
      default: r = 0;
    endcase
    return 6'(r);
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : 4;
    int k;

    alu_sched #(.ALU_WAIT(W)) u_dut (
      .clk(clk), .reset(rst),
      .req0(req0_s[g]), .req1(req1_s[g]),
      .opcode0(opc0_s[g]), .opcode1(opc1_s[g]),
      .a0(a0_s[g]), .b0(b0_s[g]), .a1(a1_s[g]), .b1(b1_s[g]),
      .ack0(ack0_s[g]), .ack1(ack1_s[g]), .result(result_s[g]),
      .alu_opcode(alu_opcode_s[g]), .alu_a(alu_a_s[g]), .alu_b(alu_b_s[g]),
      .alu_execute(alu_execute_s[g]), .alu_f(alu_f_s[g]),
      .busy(busy_s[g]), .done_cnt(done_cnt_s[g])
    );

    // ALU answers correctly only W cycles after the execute pulse, garbage otherwise
    always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else if (alu_execute_s[g]) k <= 1;
      else if (k != 0 && k < 64) k <= k + 1;
    end
    assign alu_f_s[g] = (k == W) ? alu_ref(alu_opcode_s[g], alu_a_s[g], alu_b_s[g])
                                 : alu_ref(alu_opcode_s[g], alu_a_s[g], alu_b_s[g]) ^ 6'h15;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      req0_s[d] = 1'b0; req1_s[d] = 1'b0;
      opc0_s[d] = '0; opc1_s[d] = '0;
      a0_s[d] = '0; b0_s[d] = '0; a1_s[d] = '0; b1_s[d] = '0;
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    chk(tag, {ack0_s[d], ack1_s[d], result_s[d], alu_opcode_s[d], alu_a_s[d], alu_b_s[d],
              alu_execute_s[d], busy_s[d], done_cnt_s[d]}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_zero(0, "reset_state0");
    check_zero(1, "reset_state1");
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_done[d] = 0;
      ptr_m[d] = 0;
    end
  endtask

  task automatic drive(input int d, input int r, input logic q, input logic [2:0] op,
                       input logic [2:0] a, input logic [2:0] b);
    if (r == 0) begin
      req0_s[d] = q; opc0_s[d] = op; a0_s[d] = a; b0_s[d] = b;
    end else begin
      req1_s[d] = q; opc1_s[d] = op; a1_s[d] = a; b1_s[d] = b;
    end
  endtask

  // single request on requester r; other requester's inputs churn while busy
  task automatic do_op(input int d, input int r, input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [5:0] exp_res, input int exp_lat);
    int n = 0;
    int execs = 0;
    int exec_at = 0;
    bit seen = 0;
    bit stable = 1;
    bit other_ack = 0;
    drive(d, r, 1'b1, op, a, b);
    drive(d, 1 - r, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom));
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_execute_s[d]) begin execs++; exec_at = n; end
      if ((r == 0) ? ack1_s[d] : ack0_s[d]) other_ack = 1;
      if (busy_s[d] && {alu_opcode_s[d], alu_a_s[d], alu_b_s[d]} !== {op, a, b}) stable = 0;
      if ((r == 0) ? ack0_s[d] : ack1_s[d]) seen = 1;
      else drive(d, 1 - r, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("latency", n, exp_lat);
    chk("result", result_s[d], exp_res);
    chk("exec_count", execs, (op != 3'b000) ? 1 : 0);
    chk("exec_cycle", exec_at, (op != 3'b000) ? 1 : 0);
    chk("alu_ops_stable", 32'(stable), 32'd1);
    chk("other_ack", 32'(other_ack), 32'd0);
    req0_s[d] = 1'b0;
    req1_s[d] = 1'b0;
    exp_done[d] = (exp_done[d] + 1) % 256;
    ptr_m[d] = 1 - r;
    @(negedge clk);
    chk("done_cnt", done_cnt_s[d], exp_done[d]);
    chk("result_hold", result_s[d], exp_res);
    chk("idle_after", {busy_s[d], ack0_s[d], ack1_s[d]}, 32'd0);
  endtask

  // both requesters at once; arbitration order follows the modelled pointer
  task automatic do_both(input int d, input logic [2:0] op0, input logic [2:0] x0, input logic [2:0] y0,
                         input logic [2:0] op1, input logic [2:0] x1, input logic [2:0] y1);
    logic [5:0] e [2];
    int who, n;
    bit seen, wrong;
    e[0] = alu_ref(op0, x0, y0);
    e[1] = alu_ref(op1, x1, y1);
    drive(d, 0, 1'b1, op0, x0, y0);
    drive(d, 1, 1'b1, op1, x1, y1);
    for (int s = 0; s < 2; s++) begin
      who = (s == 0) ? ptr_m[d] : 1 - ptr_m[d];
      n = 0; seen = 0; wrong = 0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if ((who == 0) ? ack1_s[d] : ack0_s[d]) wrong = 1;
        if ((who == 0) ? ack0_s[d] : ack1_s[d]) seen = 1;
      end
      chk($sformatf("both_ack%0d", who), 32'(seen), 32'd1);
      chk("both_no_overlap", 32'(wrong), 32'd0);
      chk($sformatf("both_result%0d", who), result_s[d], e[who]);
      if (who == 0) req0_s[d] = 1'b0; else req1_s[d] = 1'b0;
      exp_done[d] = (exp_done[d] + 1) % 256;
    end
    @(negedge clk);
    chk("both_done_cnt", done_cnt_s[d], exp_done[d]);
  endtask

  initial begin
    logic [2:0] op, a, b, op1, a1, b1;
    int d, r;
    clear_inputs();
    do_reset();

    // reset in the middle of WAIT aborts without ack or count
    drive(0, 0, 1'b1, 3'b001, 3'd3, 3'd2);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy_s[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero(0, "async_clear");
    begin
      bit acked = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ack0_s[0] || ack1_s[0]) acked = 1;
      end
      req0_s[0] = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ack0_s[0] || ack1_s[0]) acked = 1;
      end
      chk("abort_no_ack", 32'(acked), 32'd0);
      chk("abort_done_cnt", done_cnt_s[0], 32'd0);
    end
    exp_done[0] = 0; exp_done[1] = 0; ptr_m[0] = 0; ptr_m[1] = 0;

    do_op(0, 0, 3'b001, 3'd3, 3'd2, 6'b000101, 3);
    do_op(0, 1, 3'b000, 3'd6, 3'd7, 6'b000000, 1);

    do_reset();
    do_both(0, 3'b011, 3'd3, 3'd3, 3'b010, 3'd5, 3'd1);
    chk("req030_last_result", result_s[0], 6'b000100);

    do_op(1, 0, 3'b111, 3'd5, 3'd2, 6'b000001, 6);

    do_op(0, 1, 3'b101, 3'd5, 3'd1, alu_ref(3'b101, 3'd5, 3'd1), 3);
    do_both(0, 3'b110, 3'd2, 3'd4, 3'b100, 3'd7, 3'd2);
    do_op(1, 0, 3'b010, 3'd1, 3'd6, alu_ref(3'b010, 3'd1, 3'd6), 6);
    do_both(1, 3'b011, 3'd7, 3'd7, 3'b101, 3'd7, 3'd5);

    for (int i = 0; i < 60; i++) begin
      d = i % 2;
      op = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        op1 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
        do_both(d, op, a, b, op1, a1, b1);
      end else begin
        r = int'($urandom_range(0, 1));
        do_op(d, r, op, a, b, alu_ref(op, a, b), (op == 3'b000) ? 1 : 2 + wait_of(d));
      end
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      op = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
      do_op(0, 0, op, a, b, alu_ref(op, a, b), (op == 3'b000) ? 1 : 3);
    end
    chk("done_cnt_wrap", done_cnt_s[0], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter ALU_WAIT, default 1, number of clk cycles (1..15) between alu_execute pulse and result capture.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1 each  request from requester 0 / 1.
REQ-005 SHALL have ports opcode0, opcode1  input  3 each  ALU opcode (000 none, 001 add, 010 sub, 011 mul, 100 shr, 101 shl, 110 xnor, 111 sgt).
REQ-006 SHALL have ports a0, b0, a1, b1  input  3 each  operands per requester.
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 SHALL have port result  output  6  result of the acknowledged operation, valid while ack0 or ack1 is high.
REQ-009 SHALL have ports alu_opcode  output  3, alu_a  output  3, alu_b  output  3  operands driven to the ALU.
REQ-010 SHALL have port alu_execute  output  1  one-cycle start pulse to the ALU.
REQ-011 SHALL have port alu_f  input  6  ALU result.
REQ-012 SHALL have ports busy  output  1 (state != IDLE) and done_cnt  output  8 (completed operations).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE, if any req is high at a clk edge, SHALL grant one requester, latch its opcode/a/b, and move to ISSUE (or RESP if opcode is 000).
REQ-015 Both req high in IDLE: SHALL grant the requester named by the round-robin pointer; pointer SHALL then point to the other requester.
REQ-016 Single req high: SHALL grant it regardless of pointer; pointer SHALL then point to the other requester.
REQ-017 In ISSUE (exactly one cycle): alu_execute SHALL be 1; next state WAIT.
REQ-018 WAIT SHALL last exactly ALU_WAIT cycles; at its last edge alu_f SHALL be captured into result and state SHALL become RESP.
REQ-019 In RESP (exactly one cycle): ack of the granted requester SHALL be 1, other ack 0; done_cnt SHALL increment at the exiting edge; next state IDLE.
REQ-020 Latency: grant edge to ack high SHALL be 2+ALU_WAIT cycles (3 at default); opcode 000 SHALL give ack 1 cycle after grant with result 000000 and no alu_execute.
REQ-021 alu_opcode/alu_a/alu_b SHALL hold the latched values from ISSUE through RESP and SHALL not change while busy, regardless of requester inputs.
REQ-022 alu_execute SHALL be 0 in every state except ISSUE.
REQ-023 result SHALL hold its last value after RESP until the next capture.
REQ-024 Requester SHALL hold req and operands stable until ack, and drop req at the edge sampling ack=1; req seen in IDLE after RESP SHALL be treated as a new request.
REQ-025 req changes while busy SHALL be ignored (no queuing, no grant change).
REQ-026 done_cnt SHALL wrap 255 -> 0.

Reset
REQ-027 reset high SHALL immediately force state IDLE, pointer to requester 0, and all outputs (ack0, ack1, result, alu_opcode, alu_a, alu_b, alu_execute, busy, done_cnt) to 0.
REQ-028 Reset mid-operation SHALL abort it: no ack, no done_cnt increment; after release, first req in IDLE starts normally.

Verification
REQ-029 req0, opcode0=001, a0=3, b0=2 -> alu_execute one cycle after grant, ack0 high 3 cycles after grant, result=000101, done_cnt=1.
REQ-030 req0 and req1 both high from reset (op0=011 a0=3 b0=3, op1=010 a1=5 b1=1) -> requester 0 served first with result=001001, then requester 1 with result=000100; no overlap of acks.
REQ-031 opcode1=000 with req1 -> ack1 one cycle after grant, result=000000, alu_execute never high.
REQ-032 reset asserted during WAIT -> all outputs 0 asynchronously, no ack, done_cnt unchanged at 0; next request completes normally.
REQ-033 ALU_WAIT=4, opcode0=111, a0=5, b0=2 -> ack0 6 cycles after grant, result=000001; alu_a/alu_b stable throughout while req1 operands toggle.
REQ-034 256 back-to-back single-requester operations -> done_cnt returns to 0.
